pipe_eq_monitor: RTL and testbench

//   Downstream consumer of a pipelined equality comparator: re-aligns the

---
 rtl/pipe_eq_monitor.sv | 120 ++++++++++++
 tb/tb_pipe_eq_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_eq_monitor.sv
// Stream self-checker behind a pipelined equality comparator: realigns valid
// with the delayed eq bit, tallies matches/mismatches and latches first failure.
module pipe_eq_monitor #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned IDX_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             eq_in,
  input  logic             clear,
  output logic             out_valid,
  output logic             out_match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [IDX_W-1:0] first_err_idx,
  output logic             err_sticky,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FAIL = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [LATENCY-1:0] vdl_q, vdl_d;
  logic               out_valid_q, out_valid_d;
  logic               out_match_q, out_match_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]   mismatch_cnt_q, mismatch_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic               err_sticky_q, err_sticky_d;
  logic               v_al;

  // Oldest tap of the valid delay line lines up with eq_in.
  assign v_al = vdl_q[LATENCY-1];

  // Next-state and datapath updates; clear wins over any aligned sample.
  always_comb begin
    state_d         = state_q;
    vdl_d           = LATENCY'({vdl_q, in_valid});
    out_valid_d     = v_al;
    out_match_d     = v_al & eq_in;
    match_cnt_d     = match_cnt_q;
    mismatch_cnt_d  = mismatch_cnt_q;
    idx_d           = idx_q;
    first_err_idx_d = first_err_idx_q;
    err_sticky_d    = err_sticky_q;

    if (clear) begin
      state_d         = S_IDLE;
      vdl_d           = '0;
      out_valid_d     = 1'b0;
      out_match_d     = 1'b0;
      match_cnt_d     = '0;
      mismatch_cnt_d  = '0;
      idx_d           = '0;
      first_err_idx_d = '0;
      err_sticky_d    = 1'b0;
    end else if (v_al) begin
      idx_d = idx_q + IDX_W'(1);
      if (eq_in) begin
        match_cnt_d = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + CNT_W'(1);
      end else begin
        mismatch_cnt_d = (mismatch_cnt_q == '1) ? mismatch_cnt_q : mismatch_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        S_IDLE, S_RUN: begin
          if (eq_in) begin
            state_d = S_RUN;
          end else begin
            state_d         = S_FAIL;
            first_err_idx_d = idx_q;
            err_sticky_d    = 1'b1;
          end
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      vdl_q           <= '0;
      out_valid_q     <= 1'b0;
      out_match_q     <= 1'b0;
      match_cnt_q     <= '0;
      mismatch_cnt_q  <= '0;
      idx_q           <= '0;
      first_err_idx_q <= '0;
      err_sticky_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      vdl_q           <= vdl_d;
      out_valid_q     <= out_valid_d;
      out_match_q     <= out_match_d;
      match_cnt_q     <= match_cnt_d;
      mismatch_cnt_q  <= mismatch_cnt_d;
      idx_q           <= idx_d;
      first_err_idx_q <= first_err_idx_d;
      err_sticky_q    <= err_sticky_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_match     = out_match_q;
  assign match_cnt     = match_cnt_q;
  assign mismatch_cnt  = mismatch_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign err_sticky    = err_sticky_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pipe_eq_monitor.sv
// Directed bench for pipe_eq_monitor: a default-width instance and a
// narrow-counter instance share one stimulus stream.
module tb_pipe_eq_monitor;

  localparam int L = 3;

  logic clk;
  logic rst;
  logic in_valid;
  logic eq_in;
  logic clear;

  logic        ov, om, stk;
  logic [15:0] mc, mmc, fei;
  logic [1:0]  st;

  logic        ov4, om4, stk4;
  logic [3:0]  mc4, mmc4, fei4;
  logic [1:0]  st4;

  int checks = 0;
  int errors = 0;

  pipe_eq_monitor #(.LATENCY(L), .CNT_W(16), .IDX_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .eq_in(eq_in), .clear(clear),
    .out_valid(ov), .out_match(om), .match_cnt(mc), .mismatch_cnt(mmc),
    .first_err_idx(fei), .err_sticky(stk), .state(st)
  );

  pipe_eq_monitor #(.LATENCY(L), .CNT_W(4), .IDX_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .eq_in(eq_in), .clear(clear),
    .out_valid(ov4), .out_match(om4), .match_cnt(mc4), .mismatch_cnt(mmc4),
    .first_err_idx(fei4), .err_sticky(stk4), .state(st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int vi; int eq; int clr;
    int ov; int om; int mc; int mmc; int fei; int stk; int st;
  } vec_t;

  vec_t tbl [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input int e_ov, input int e_om, input int e_mc,
                         input int e_mmc, input int e_fei, input int e_stk, input int e_st);
    chk($sformatf("%s.out_valid", nm), int'(ov), e_ov);
    chk($sformatf("%s.out_match", nm), int'(om), e_om);
    chk($sformatf("%s.match_cnt", nm), int'(mc), e_mc);
    chk($sformatf("%s.mismatch_cnt", nm), int'(mmc), e_mmc);
    chk($sformatf("%s.first_err_idx", nm), int'(fei), e_fei);
    chk($sformatf("%s.err_sticky", nm), int'(stk), e_stk);
    chk($sformatf("%s.state", nm), int'(st), e_st);
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    eq_in    = 1'b0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
  endtask

  // n back-to-back samples; eq_in is presented L cycles later, low where bad bit set.
  task automatic run_burst(input int n, input logic [31:0] bad);
    logic [31:0] b;
    b = bad;
    for (int c = 0; c < n + L + 1; c++) begin
      in_valid = (c < n);
      eq_in    = (c >= L && c - L < n) ? ~b[c-L] : 1'b0;
      step();
    end
    in_valid = 1'b0;
    eq_in    = 1'b0;
  endtask

  initial begin
    int first_ov;

    //           vi eq clr  ov om mc mmc fei stk st
    tbl[0]  = '{1, 0, 0,   0, 0, 0, 0,  0,  0,  0};
    tbl[1]  = '{0, 0, 0,   0, 0, 0, 0,  0,  0,  0};
    tbl[2]  = '{1, 0, 0,   0, 0, 0, 0,  0,  0,  0};
    tbl[3]  = '{1, 1, 0,   1, 1, 1, 0,  0,  0,  1};
    tbl[4]  = '{0, 0, 0,   0, 0, 1, 0,  0,  0,  1};
    tbl[5]  = '{1, 1, 0,   1, 1, 2, 0,  0,  0,  1};
    tbl[6]  = '{0, 1, 0,   1, 1, 3, 0,  0,  0,  1};
    tbl[7]  = '{0, 0, 0,   0, 0, 3, 0,  0,  0,  1};
    tbl[8]  = '{0, 1, 0,   1, 1, 4, 0,  0,  0,  1};
    tbl[9]  = '{1, 0, 0,   0, 0, 4, 0,  0,  0,  1};
    tbl[10] = '{1, 0, 0,   0, 0, 4, 0,  0,  0,  1};
    tbl[11] = '{0, 0, 0,   0, 0, 4, 0,  0,  0,  1};
    tbl[12] = '{0, 0, 0,   1, 0, 4, 1,  4,  1,  2};
    tbl[13] = '{0, 1, 0,   1, 1, 5, 1,  4,  1,  2};
    tbl[14] = '{0, 0, 0,   0, 0, 5, 1,  4,  1,  2};
    tbl[15] = '{1, 1, 1,   0, 0, 0, 0,  0,  0,  0};
    tbl[16] = '{0, 1, 0,   0, 0, 0, 0,  0,  0,  0};
    tbl[17] = '{0, 1, 0,   0, 0, 0, 0,  0,  0,  0};
    tbl[18] = '{0, 1, 0,   0, 0, 0, 0,  0,  0,  0};

    rst = 1'b1; in_valid = 1'b0; eq_in = 1'b0; clear = 1'b0;

    // Reset state, then eq_in toggling without any valid.
    step(); step();
    chk_dut("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.match_cnt4", int'(mc4), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eq_in = ~eq_in;
      step();
      chk_dut($sformatf("noval%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end
    eq_in = 1'b0;

    // Gapped valid pattern, mismatch into FAIL, then clear with in_valid.
    for (int i = 0; i < 19; i++) begin
      in_valid = tbl[i].vi[0];
      eq_in    = tbl[i].eq[0];
      clear    = tbl[i].clr[0];
      step();
      chk_dut($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].om, tbl[i].mc, tbl[i].mmc,
              tbl[i].fei, tbl[i].stk, tbl[i].st);
    end
    clear = 1'b0; in_valid = 1'b0; eq_in = 1'b0;

    // Latency of the first out_valid for 5 back-to-back matches.
    do_clear();
    first_ov = -1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 5);
      eq_in    = 1'b1;
      step();
      if (ov && first_ov < 0) first_ov = c + 1;
    end
    in_valid = 1'b0; eq_in = 1'b0;
    chk("b2b.first_out_valid", first_ov, L + 1);
    chk_dut("b2b", 0, 0, 5, 0, 0, 0, 1);

    // Mismatches on samples 3 and 6 of 8.
    do_clear();
    run_burst(8, 32'h0000_0048);
    chk_dut("mm36", 0, 0, 6, 2, 3, 1, 2);

    // Saturation and index wrap in the narrow instance.
    do_clear();
    run_burst(21, 32'h0010_0000);
    chk("sat.match_cnt4", int'(mc4), 15);
    chk("sat.mismatch_cnt4", int'(mmc4), 1);
    chk("sat.first_err_idx4", int'(fei4), 4);
    chk("sat.state4", int'(st4), 2);
    chk("sat.err_sticky4", int'(stk4), 1);
    chk("sat.match_cnt", int'(mc), 20);
    chk("sat.first_err_idx", int'(fei), 20);

    // Clear while three samples are in flight drops them all.
    in_valid = 1'b1; eq_in = 1'b1;
    for (int c = 0; c < 3; c++) step();
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_dut("clr_flight", 0, 0, 0, 0, 0, 0, 0);
    chk("clr_flight.match_cnt4", int'(mc4), 0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("clr_flight.ov%0d", c), int'(ov), 0);
    end
    chk_dut("clr_flight_end", 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-stream loses in-flight samples.
    in_valid = 1'b1; eq_in = 1'b0;
    step(); step();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk_dut("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("rst_mid.ov%0d", c), int'(ov), 0);
    end
    chk_dut("rst_mid_end", 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
